// File: rtl/mp3_frame_sequencer.sv
// MPEG-1 Layer III frame sequencer: sync hunt, header decode, CRC skip, side-info / main-data steering.
// Optional MP3_FRAME_SEQ_STATS_EN adds saturating frame_count / resync_count outputs.
module mp3_frame_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  si_data,
    output logic        si_valid,
    output logic [7:0]  md_data,
    output logic        md_valid,
    input  logic        md_ready,
    output logic        hdr_valid,
    output logic [3:0]  bitrate_idx,
    output logic [1:0]  srate_idx,
    output logic        padding,
    output logic [1:0]  channel_mode,
    output logic [1:0]  mode_ext,
    output logic [10:0] frame_bytes,
    output logic [10:0] main_bytes,
    output logic        bad_hdr
`ifdef MP3_FRAME_SEQ_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] resync_count
`endif
);

    typedef enum logic [2:0] {HUNT0, HUNT1, HDR2, HDR3, CRC, SIDE, MAIN} state_t;

    state_t      state;
    logic [10:0] cnt;
    logic        prot;
    logic [3:0]  br_q;
    logic [1:0]  sr_q;
    logic        pad_q;
    logic        acc;
    logic        hdr2_bad;
    logic [10:0] base_len, frame_len, hdr_side, crc_len, main_len, side_len_q;

    assign in_ready = (state == MAIN) ? md_ready : 1'b1;
    assign acc      = in_valid & in_ready;
    assign md_valid = (state == MAIN) & in_valid;
    assign md_data  = in_data;

    assign hdr2_bad   = (in_data[7:4] == 4'd0) || (in_data[7:4] == 4'hF) || (in_data[3:2] == 2'b11);
    assign hdr_side   = (in_data[7:6] == 2'b11) ? 11'd17 : 11'd32;
    assign side_len_q = (channel_mode == 2'b11) ? 11'd17 : 11'd32;
    assign crc_len    = prot ? 11'd0 : 11'd2;
    assign frame_len  = base_len + {10'd0, pad_q};
    assign main_len   = frame_len - 11'd4 - crc_len - hdr_side;

    function automatic logic [10:0] pick(input logic [1:0] sr, input logic [10:0] a, b, c);
        case (sr)
            2'd0:    pick = a;
            2'd1:    pick = b;
            default: pick = c;
        endcase
    endfunction

    // floor(144000*kbps/Hz) for 44.1k / 48k / 32k
    always_comb begin
        base_len = 11'd0;
        case (br_q)
            4'd1:    base_len = pick(sr_q, 11'd104,  11'd96,  11'd144);
            4'd2:    base_len = pick(sr_q, 11'd130,  11'd120, 11'd180);
            4'd3:    base_len = pick(sr_q, 11'd156,  11'd144, 11'd216);
            4'd4:    base_len = pick(sr_q, 11'd182,  11'd168, 11'd252);
            4'd5:    base_len = pick(sr_q, 11'd208,  11'd192, 11'd288);
            4'd6:    base_len = pick(sr_q, 11'd261,  11'd240, 11'd360);
            4'd7:    base_len = pick(sr_q, 11'd313,  11'd288, 11'd432);
            4'd8:    base_len = pick(sr_q, 11'd365,  11'd336, 11'd504);
            4'd9:    base_len = pick(sr_q, 11'd417,  11'd384, 11'd576);
            4'd10:   base_len = pick(sr_q, 11'd522,  11'd480, 11'd720);
            4'd11:   base_len = pick(sr_q, 11'd626,  11'd576, 11'd864);
            4'd12:   base_len = pick(sr_q, 11'd731,  11'd672, 11'd1008);
            4'd13:   base_len = pick(sr_q, 11'd835,  11'd768, 11'd1152);
            4'd14:   base_len = pick(sr_q, 11'd1044, 11'd960, 11'd1440);
            default: base_len = 11'd0;
        endcase
    end

`ifdef MP3_FRAME_SEQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT0;
            cnt          <= 11'd0;
            prot         <= 1'b0;
            br_q         <= 4'd0;
            sr_q         <= 2'd0;
            pad_q        <= 1'b0;
            si_data      <= 8'd0;
            si_valid     <= 1'b0;
            hdr_valid    <= 1'b0;
            bitrate_idx  <= 4'd0;
            srate_idx    <= 2'd0;
            padding      <= 1'b0;
            channel_mode <= 2'd0;
            mode_ext     <= 2'd0;
            frame_bytes  <= 11'd0;
            main_bytes   <= 11'd0;
            bad_hdr      <= 1'b0;
`ifdef MP3_FRAME_SEQ_STATS_EN
            frame_count  <= 16'd0;
            resync_count <= 16'd0;
`endif
        end else begin
            hdr_valid <= 1'b0;
            bad_hdr   <= 1'b0;
            si_valid  <= 1'b0;
            if (acc) begin
                case (state)
                    HUNT0: if (in_data == 8'hFF) state <= HUNT1;
                    HUNT1: begin
                        if ((in_data & 8'hFE) == 8'hFA) begin
                            prot  <= in_data[0];
                            state <= HDR2;
                        end else if (in_data != 8'hFF) begin
                            state <= HUNT0;
`ifdef MP3_FRAME_SEQ_STATS_EN
                            resync_count <= sat_inc(resync_count);
`endif
                        end
                    end
                    HDR2: begin
                        br_q  <= in_data[7:4];
                        sr_q  <= in_data[3:2];
                        pad_q <= in_data[1];
                        if (hdr2_bad) begin
                            bad_hdr <= 1'b1;
                            state   <= HUNT0;
`ifdef MP3_FRAME_SEQ_STATS_EN
                            resync_count <= sat_inc(resync_count);
`endif
                        end else begin
                            state <= HDR3;
                        end
                    end
                    HDR3: begin
                        // Publish all header fields together so they stay coherent until the next pulse
                        hdr_valid    <= 1'b1;
                        bitrate_idx  <= br_q;
                        srate_idx    <= sr_q;
                        padding      <= pad_q;
                        channel_mode <= in_data[7:6];
                        mode_ext     <= in_data[5:4];
                        frame_bytes  <= frame_len;
                        main_bytes   <= main_len;
                        state        <= prot ? SIDE : CRC;
                        cnt          <= prot ? hdr_side : 11'd2;
                    end
                    CRC: begin
                        if (cnt == 11'd1) begin
                            state <= SIDE;
                            cnt   <= side_len_q;
                        end else begin
                            cnt <= cnt - 11'd1;
                        end
                    end
                    SIDE: begin
                        si_data  <= in_data;
                        si_valid <= 1'b1;
                        if (cnt == 11'd1) begin
                            cnt <= main_bytes;
                            if (main_bytes == 11'd0) begin
                                state <= HUNT0;
`ifdef MP3_FRAME_SEQ_STATS_EN
                                frame_count <= sat_inc(frame_count);
`endif
                            end else begin
                                state <= MAIN;
                            end
                        end else begin
                            cnt <= cnt - 11'd1;
                        end
                    end
                    MAIN: begin
                        if (cnt == 11'd1) begin
                            state <= HUNT0;
`ifdef MP3_FRAME_SEQ_STATS_EN
                            frame_count <= sat_inc(frame_count);
`endif
                        end else begin
                            cnt <= cnt - 11'd1;
                        end
                    end
                    default: state <= HUNT0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// Directed bench for mp3_frame_sequencer: frame-level model builds expected side-info, main-data
// and header queues from the header rules; one negedge process compares DUT outputs against them.
module tb_mp3_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  si_data;
    logic        si_valid;
    logic [7:0]  md_data;
    logic        md_valid;
    logic        md_ready = 1'b1;
    logic        hdr_valid;
    logic [3:0]  bitrate_idx;
    logic [1:0]  srate_idx;
    logic        padding;
    logic [1:0]  channel_mode;
    logic [1:0]  mode_ext;
    logic [10:0] frame_bytes;
    logic [10:0] main_bytes;
    logic        bad_hdr;

    mp3_frame_sequencer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .si_data(si_data), .si_valid(si_valid), .md_data(md_data), .md_valid(md_valid),
        .md_ready(md_ready), .hdr_valid(hdr_valid), .bitrate_idx(bitrate_idx),
        .srate_idx(srate_idx), .padding(padding), .channel_mode(channel_mode),
        .mode_ext(mode_ext), .frame_bytes(frame_bytes), .main_bytes(main_bytes),
        .bad_hdr(bad_hdr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] br;
        logic [1:0] sr;
        logic       pad;
        logic [1:0] mode;
        logic [1:0] mext;
        int         fb;
        int         mb;
    } hdr_t;

    hdr_t       hq[$];
    logic [7:0] siq[$];
    logic [7:0] mdq[$];
    int         exp_bad = 0;
    bit         chk_en = 1'b0;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event", name);
    endtask

    function automatic int kbps_of(input logic [3:0] i);
        int t[16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
        return t[i];
    endfunction

    function automatic int hz_of(input logic [1:0] i);
        int t[4] = '{44100, 48000, 32000, 1};
        return t[i];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (md_valid) check("in_ready_tracks_md_ready", in_ready, md_ready);
            if (md_valid && md_ready) begin
                if (mdq.size() == 0) fail_now("md_extra_byte");
                else check("md_data", md_data, mdq.pop_front());
            end
            if (si_valid) begin
                if (siq.size() == 0) fail_now("si_extra_byte");
                else check("si_data", si_data, siq.pop_front());
            end
            if (hdr_valid) begin
                if (hq.size() == 0) fail_now("hdr_valid_extra");
                else begin
                    hdr_t h;
                    h = hq.pop_front();
                    check("bitrate_idx", bitrate_idx, h.br);
                    check("srate_idx", srate_idx, h.sr);
                    check("padding", padding, h.pad);
                    check("channel_mode", channel_mode, h.mode);
                    check("mode_ext", mode_ext, h.mext);
                    check("frame_bytes", frame_bytes, h.fb);
                    check("main_bytes", main_bytes, h.mb);
                end
            end
            if (bad_hdr) begin
                if (exp_bad == 0) fail_now("bad_hdr_extra");
                else exp_bad--;
            end
        end
    end

    // One byte offered until accepted; inputs change 2ns after posedge, acceptance sampled at negedge
    task automatic send_byte(input logic [7:0] b, input bit togg);
        bit ok = 1'b0;
        int tries = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!ok) begin
            md_ready = togg ? ~md_ready : 1'b1;
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
            tries++;
            if (!ok && tries > 8) begin
                fail_now("stall_timeout");
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b1, b2, b3, input bit togg, input int cut);
        logic [7:0] s[$];
        logic [7:0] r;
        hdr_t h;
        int sl, cl, n;
        h.br   = b2[7:4];
        h.sr   = b2[3:2];
        h.pad  = b2[1];
        h.mode = b3[7:6];
        h.mext = b3[5:4];
        h.fb   = 144000 * kbps_of(h.br) / hz_of(h.sr) + int'(h.pad);
        sl     = (h.mode == 2'b11) ? 17 : 32;
        cl     = b1[0] ? 0 : 2;
        h.mb   = h.fb - 4 - cl - sl;
        hq.push_back(h);
        s.push_back(8'hFF); s.push_back(b1); s.push_back(b2); s.push_back(b3);
        for (int i = 0; i < cl; i++) s.push_back(8'hFF);
        for (int i = 0; i < sl; i++) begin r = 8'($urandom); s.push_back(r); siq.push_back(r); end
        for (int i = 0; i < h.mb; i++) begin r = 8'($urandom); s.push_back(r); mdq.push_back(r); end
        n = (cut > 0) ? cut : s.size();
        for (int i = 0; i < n; i++) send_byte(s[i], togg);
        idle(3);
    endtask

    task automatic end_check(input string name);
        check({name, "_si_left"}, siq.size(), 0);
        check({name, "_md_left"}, mdq.size(), 0);
        check({name, "_hdr_left"}, hq.size(), 0);
    endtask

    task automatic reset_state_check(input string name);
        @(negedge clk);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_si_valid"}, si_valid, 0);
        check({name, "_si_data"}, si_data, 0);
        check({name, "_md_valid"}, md_valid, 0);
        check({name, "_hdr_valid"}, hdr_valid, 0);
        check({name, "_bad_hdr"}, bad_hdr, 0);
        check({name, "_frame_bytes"}, frame_bytes, 0);
        check({name, "_main_bytes"}, main_bytes, 0);
        check({name, "_hdr_fields"}, {bitrate_idx, srate_idx, padding, channel_mode, mode_ext}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        reset_state_check("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // Test 1: stereo 128k/44.1k, no CRC
        send_frame(8'hFB, 8'h90, 8'h00, 1'b0, 0);
        end_check("t1");
        check("t1_frame_bytes_lit", frame_bytes, 417);
        check("t1_main_bytes_lit", main_bytes, 381);

        // Test 2: mono, then padded
        send_frame(8'hFB, 8'h90, 8'hC0, 1'b0, 0);
        end_check("t2a");
        check("t2a_main_bytes_lit", main_bytes, 396);
        send_frame(8'hFB, 8'h92, 8'h00, 1'b0, 0);
        end_check("t2b");
        check("t2b_frame_bytes_lit", frame_bytes, 418);
        check("t2b_main_bytes_lit", main_bytes, 382);

        // Test 3: CRC present
        send_frame(8'hFA, 8'h90, 8'h00, 1'b0, 0);
        end_check("t3");
        check("t3_main_bytes_lit", main_bytes, 379);

        // Test 4: garbage then FF FF lock, bad bitrate, bad sample rate
        send_byte(8'h12, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_frame(8'hFB, 8'h90, 8'h00, 1'b0, 0);
        end_check("t4a");
        exp_bad = 1;
        send_byte(8'hFF, 1'b0); send_byte(8'hFB, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h00, 1'b0);
        idle(3);
        check("t4b_bad_bitrate_pulse", exp_bad, 0);
        exp_bad = 1;
        send_byte(8'hFF, 1'b0); send_byte(8'hFB, 1'b0); send_byte(8'h9C, 1'b0); send_byte(8'h00, 1'b0);
        idle(3);
        check("t4c_bad_srate_pulse", exp_bad, 0);
        end_check("t4c");

        // Table corners: 128k/48k joint stereo, 32k/32k mono
        send_frame(8'hFB, 8'h94, 8'h50, 1'b0, 0);
        end_check("t4d");
        check("t4d_frame_bytes_lit", frame_bytes, 384);
        check("t4d_main_bytes_lit", main_bytes, 348);
        send_frame(8'hFB, 8'h18, 8'hC0, 1'b0, 0);
        end_check("t4e");
        check("t4e_frame_bytes_lit", frame_bytes, 144);
        check("t4e_main_bytes_lit", main_bytes, 123);

        // Test 5: md_ready toggling
        send_frame(8'hFB, 8'h90, 8'h00, 1'b1, 0);
        end_check("t5");
        md_ready = 1'b1;

        // Test 6: reset after 10 side-info bytes, then a clean frame
        send_frame(8'hFB, 8'h90, 8'h00, 1'b0, 14);
        check("t6_si_seen", siq.size(), 22);
        chk_en = 1'b0;
        rst = 1'b1;
        idle(2);
        reset_state_check("t6_reset");
        siq.delete(); mdq.delete(); hq.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        chk_en = 1'b1;
        send_frame(8'hFB, 8'h90, 8'h00, 1'b0, 0);
        end_check("t6b");
        check("t6b_frame_bytes_lit", frame_bytes, 417);
        check("t6b_main_bytes_lit", main_bytes, 381);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
